wb_queue: RTL and testbench

Register writeback queue that produces the write-port traffic (`wen`/`waddr`/`wdata`) for the NPC general-purpose register file. Completed results arrive over a valid/ready handshake, are buffered in a small in-order FIFO, and are drained one per cycle onto the register-file write port. A combinational lookup port lets the decode stage read pending, not-yet-written results (bypass), so reads through the register file plus this queue always return the architecturally latest value.

---
 rtl/wb_queue.sv | 104 ++++++++++
 tb/tb_wb_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// Register-file writeback queue: in-order FIFO of {rd, data} drained one entry per
// cycle onto the write port, with a youngest-match bypass lookup over pending entries.
module wb_queue #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_WIDTH-1:0]   in_rd,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    stall,
    output logic                    rf_wen,
    output logic [ADDR_WIDTH-1:0]   rf_waddr,
    output logic [DATA_WIDTH-1:0]   rf_wdata,
    input  logic [ADDR_WIDTH-1:0]   q_addr,
    output logic                    q_hit,
    output logic [DATA_WIDTH-1:0]   q_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] rd_mem_r   [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_r [DEPTH];
    logic [PTR_W-1:0]      head_r;
    logic [PTR_W-1:0]      tail_r;
    logic [CNT_W-1:0]      count_r;

    logic                  store_s;
    logic                  drain_s;
    logic                  hit_s;
    logic [DATA_WIDTH-1:0] hit_data_s;
    logic [PTR_W-1:0]      idx_s;

    assign in_ready = (count_r != CNT_W'(DEPTH));
    assign empty    = (count_r == {CNT_W{1'b0}});
    assign count    = count_r;

    // x0 results complete the handshake but are never stored
    assign store_s  = in_valid && in_ready && (in_rd != {ADDR_WIDTH{1'b0}});
    assign drain_s  = !empty && !stall;

    assign rf_wen   = drain_s;
    assign rf_waddr = rd_mem_r[head_r];
    assign rf_wdata = data_mem_r[head_r];
    assign q_hit    = hit_s;
    assign q_data   = hit_data_s;

    // Pointer and occupancy state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (store_s) begin
                tail_r <= tail_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                tail_r <= tail_r;
            end
            if (drain_s) begin
                head_r <= head_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                head_r <= head_r;
            end
            count_r <= count_r + CNT_W'(store_s) - CNT_W'(drain_s);
        end
    end

    // Entry storage; contents are qualified by count, so no reset is needed
    always_ff @(posedge clk) begin
        if (store_s) begin
            rd_mem_r[tail_r]   <= in_rd;
            data_mem_r[tail_r] <= in_data;
        end else begin
            rd_mem_r[tail_r]   <= rd_mem_r[tail_r];
            data_mem_r[tail_r] <= data_mem_r[tail_r];
        end
    end

    // Bypass search: walk oldest to youngest so the youngest match is the one kept
    always_comb begin
        hit_s      = 1'b0;
        hit_data_s = {DATA_WIDTH{1'b0}};
        idx_s      = head_r;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s = head_r + PTR_W'(i);
            if ((CNT_W'(i) < count_r) && (rd_mem_r[idx_s] == q_addr) &&
                (q_addr != {ADDR_WIDTH{1'b0}})) begin
                hit_s      = 1'b1;
                hit_data_s = data_mem_r[idx_s];
            end else begin
                hit_s      = hit_s;
                hit_data_s = hit_data_s;
            end
        end
    end

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: a vector table for streaming, bypass and x0 cases,
// plus hand-written sequences for reset, full/wrap and asynchronous mid-drain reset.
module tb_wb_queue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        stall;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  q_addr;
    logic        q_hit;
    logic [31:0] q_data;
    logic [2:0]  count;
    logic        empty;

    int n_cmp;
    int n_bad;

    wb_queue #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
        .stall(stall),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data),
        .count(count), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  rd;
        logic [31:0] d;
        logic        st;
        logic [4:0]  qa;
        logic        e_rdy;
        logic        e_wen;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_hit;
        logic [31:0] e_qd;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d,
                         input logic st, input logic [4:0] qa);
        in_valid = v;
        in_rd    = rd;
        in_data  = d;
        stall    = st;
        q_addr   = qa;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        //          v     rd     d             st    qa      rdy   wen   wa     wd      hit   qd      cnt
        vecs[0]  = '{1'b1, 5'd1, 32'h10,       1'b0, 5'd1, 1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 32'h0,  3'd0};
        vecs[1]  = '{1'b1, 5'd2, 32'h11,       1'b0, 5'd1, 1'b1, 1'b1, 5'd1, 32'h10, 1'b1, 32'h10, 3'd1};
        vecs[2]  = '{1'b1, 5'd3, 32'h12,       1'b0, 5'd1, 1'b1, 1'b1, 5'd2, 32'h11, 1'b0, 32'h0,  3'd1};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd3, 1'b1, 1'b1, 5'd3, 32'h12, 1'b1, 32'h12, 3'd1};
        vecs[4]  = '{1'b1, 5'd7, 32'hAA,       1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 32'h0,  3'd0};
        vecs[5]  = '{1'b1, 5'd7, 32'hBB,       1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 32'h0,  1'b1, 32'hAA, 3'd1};
        vecs[6]  = '{1'b1, 5'd2, 32'hCC,       1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 32'h0,  1'b1, 32'hBB, 3'd2};
        vecs[7]  = '{1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 32'h0,  1'b1, 32'hBB, 3'd3};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 32'h0,  3'd3};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 32'h0,  3'd3};
        vecs[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 32'h0,  1'b1, 32'hCC, 3'd3};
        vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 32'hAA, 1'b1, 32'hBB, 3'd3};
        vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 32'hBB, 1'b1, 32'hBB, 3'd2};
        vecs[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd7, 1'b1, 1'b1, 5'd2, 32'hCC, 1'b0, 32'h0,  3'd1};
        vecs[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd2, 1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 32'h0,  3'd0};

        // Reset held with an offer pending: nothing stored
        rst_n = 1'b0;
        drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd3);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_wen",   {31'd0, rf_wen}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_hit",   {31'd0, q_hit}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rel_wen",   {31'd0, rf_wen}, 32'd1);
        chk("rel_waddr", {27'd0, rf_waddr}, 32'd3);
        chk("rel_wdata", rf_wdata, 32'h33);
        chk("rel_count", {29'd0, count}, 32'd1);
        in_valid = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].rd, vecs[i].d, vecs[i].st, vecs[i].qa);
            #1;
            chk($sformatf("v%0d_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_rdy});
            chk($sformatf("v%0d_wen", i),   {31'd0, rf_wen},   {31'd0, vecs[i].e_wen});
            if (vecs[i].e_wen) begin
                chk($sformatf("v%0d_waddr", i), {27'd0, rf_waddr}, {27'd0, vecs[i].e_wa});
                chk($sformatf("v%0d_wdata", i), rf_wdata, vecs[i].e_wd);
            end
            chk($sformatf("v%0d_hit", i),   {31'd0, q_hit}, {31'd0, vecs[i].e_hit});
            chk($sformatf("v%0d_qdata", i), q_data, vecs[i].e_qd);
            chk($sformatf("v%0d_count", i), {29'd0, count}, {29'd0, vecs[i].e_cnt});
            chk($sformatf("v%0d_empty", i), {31'd0, empty}, {31'd0, (vecs[i].e_cnt == 3'd0)});
        end

        // Back-to-back streaming rd=1..8, each write one cycle after its accept
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i <= 8) drive(1'b1, 5'(i), 32'h10 + 32'(i - 1), 1'b0, 5'd0);
            else        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
            #1;
            if (i == 1) begin
                chk("str_wen0", {31'd0, rf_wen}, 32'd0);
                chk("str_cnt0", {29'd0, count}, 32'd0);
            end else begin
                chk($sformatf("str%0d_wen", i), {31'd0, rf_wen}, 32'd1);
                chk($sformatf("str%0d_waddr", i), {27'd0, rf_waddr}, 32'(i - 1));
                chk($sformatf("str%0d_wdata", i), rf_wdata, 32'h10 + 32'(i - 2));
                chk($sformatf("str%0d_cnt", i), {29'd0, count}, 32'd1);
                chk($sformatf("str%0d_ready", i), {31'd0, in_ready}, 32'd1);
            end
        end
        @(negedge clk);
        #1;
        chk("str_end_wen", {31'd0, rf_wen}, 32'd0);
        chk("str_end_cnt", {29'd0, count}, 32'd0);

        // Fill under stall, then drain across the pointer wrap
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive(1'b1, 5'(c + 1), 32'h21 + 32'(c), 1'b1, 5'd0);
            #1;
            chk($sformatf("fill%0d_ready", c), {31'd0, in_ready}, 32'd1);
            chk($sformatf("fill%0d_cnt", c), {29'd0, count}, 32'(c));
            chk($sformatf("fill%0d_wen", c), {31'd0, rf_wen}, 32'd0);
        end
        @(negedge clk);
        drive(1'b1, 5'd5, 32'h25, 1'b1, 5'd0);
        #1;
        chk("full_ready", {31'd0, in_ready}, 32'd0);
        chk("full_cnt",   {29'd0, count}, 32'd4);
        @(negedge clk);
        stall = 1'b0;
        #1;
        chk("full_drain_ready", {31'd0, in_ready}, 32'd0);
        chk("full_drain_wen",   {31'd0, rf_wen}, 32'd1);
        chk("wrap_waddr1",      {27'd0, rf_waddr}, 32'd1);
        chk("wrap_wdata1",      rf_wdata, 32'h21);
        @(negedge clk);
        #1;
        chk("after_drain_ready", {31'd0, in_ready}, 32'd1);
        chk("after_drain_cnt",   {29'd0, count}, 32'd3);
        chk("wrap_waddr2",       {27'd0, rf_waddr}, 32'd2);
        for (int k = 3; k <= 5; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk($sformatf("wrap%0d_wen", k), {31'd0, rf_wen}, 32'd1);
            chk($sformatf("wrap%0d_waddr", k), {27'd0, rf_waddr}, 32'(k));
            chk($sformatf("wrap%0d_wdata", k), rf_wdata, 32'h20 + 32'(k));
            chk($sformatf("wrap%0d_cnt", k), {29'd0, count}, (k == 3) ? 32'd3 : ((k == 4) ? 32'd2 : 32'd1));
        end
        @(negedge clk);
        #1;
        chk("wrap_end_wen", {31'd0, rf_wen}, 32'd0);
        chk("wrap_end_cnt", {29'd0, count}, 32'd0);

        // Asynchronous reset in the middle of a drain
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive(1'b1, 5'(c + 4), 32'h40 + 32'(c), 1'b1, 5'd5);
        end
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd5);
        #1;
        chk("mid_pre_wen", {31'd0, rf_wen}, 32'd1);
        chk("mid_pre_cnt", {29'd0, count}, 32'd3);
        chk("mid_pre_hit", {31'd0, q_hit}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wen",   {31'd0, rf_wen}, 32'd0);
        chk("mid_rst_cnt",   {29'd0, count}, 32'd0);
        chk("mid_rst_empty", {31'd0, empty}, 32'd1);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_hit",   {31'd0, q_hit}, 32'd0);
        chk("mid_rst_qdata", q_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_cnt", {29'd0, count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
